// File: rtl/nbin_encoder.sv
// nbin_encoder: write-side packer for the zero-skipping NBin buffer.
// Dense rows of Tn lanes arrive one brick position at a time. Each lane's
// non-zero neurons are compacted into (value, offset) pairs in a staging
// array. At the end of the brick the packed rows are written into the
// NBin/offset register-file pair, one row per cycle, and a done pulse
// reports the brick's length and base address.
module nbin_encoder #(
  parameter int N         = 16,
  parameter int Tn        = 16,
  parameter int OFFSET_SZ = 4,
  parameter int ADDR_SZ   = 6,
  parameter int NUM_WORDS = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [Tn*N-1:0]           i_data,
  input  logic                      i_last,
  input  logic                      i_clear,
  output logic [Tn*N-1:0]           o_nbin_data,
  output logic [Tn*OFFSET_SZ-1:0]   o_offset_data,
  output logic                      o_wen,
  output logic [ADDR_SZ-1:0]        o_addr,
  output logic                      o_brick_done,
  output logic [OFFSET_SZ:0]        o_brick_len,
  output logic [ADDR_SZ-1:0]        o_brick_base
);

  // Brick depth: one staging row per possible in-brick position.
  localparam int B = 1 << OFFSET_SZ;

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [OFFSET_SZ-1:0] POS_LAST  = OFFSET_SZ'(B - 1);
  localparam logic [OFFSET_SZ-1:0] POS_ONE   = OFFSET_SZ'(1);
  localparam logic [OFFSET_SZ:0]   CNT_ONE   = (OFFSET_SZ + 1)'(1);
  localparam logic [ADDR_SZ-1:0]   ADDR_LAST = ADDR_SZ'(NUM_WORDS - 1);
  localparam logic [ADDR_SZ-1:0]   ADDR_ONE  = ADDR_SZ'(1);

  // Control state
  logic [1:0]           state_q, state_d;
  logic                 ready_q, ready_d;
  logic [OFFSET_SZ-1:0] pos_q, pos_d;
  logic [OFFSET_SZ-1:0] r_q, r_d;
  logic [OFFSET_SZ:0]   cnt_q [Tn];
  logic [OFFSET_SZ:0]   cnt_d [Tn];
  logic [OFFSET_SZ:0]   maxc_q, maxc_d;
  logic [ADDR_SZ-1:0]   wptr_q, wptr_d;
  logic [ADDR_SZ-1:0]   base_q, base_d;

  // Staging array: stage[row][lane] holds one compacted (value, offset) pair.
  logic [N-1:0]         stage_val_q [B][Tn];
  logic [OFFSET_SZ-1:0] stage_off_q [B][Tn];

  // Per-row helpers
  logic [N-1:0]         lane_val [Tn];
  logic [Tn-1:0]        lane_nz;
  logic [OFFSET_SZ:0]   cnt_upd [Tn];
  logic [OFFSET_SZ:0]   maxc_upd;
  logic                 accept;
  logic                 brick_end;
  logic                 drain_last;
  logic [ADDR_SZ-1:0]   wptr_inc;

  // Split the dense row into lanes and compute the counts after this row.
  always_comb begin
    for (int l = 0; l < Tn; l++) begin
      lane_val[l] = i_data[l*N +: N];
      lane_nz[l]  = |i_data[l*N +: N];
      cnt_upd[l]  = cnt_q[l] + {{OFFSET_SZ{1'b0}}, lane_nz[l]};
    end
  end

  // Longest compacted lane once the current row is included; this is the
  // number of rows the brick will occupy in the register file.
  always_comb begin
    maxc_upd = '0;
    for (int l = 0; l < Tn; l++) begin
      if (cnt_upd[l] > maxc_upd) begin
        maxc_upd = cnt_upd[l];
      end
    end
  end

  // Handshake, brick-end detection and pointer arithmetic.
  always_comb begin
    accept     = i_valid && ready_q;
    brick_end  = accept && ((pos_q == POS_LAST) || i_last);
    drain_last = ({1'b0, r_q} == (maxc_q - CNT_ONE));
    wptr_inc   = (wptr_q == ADDR_LAST) ? '0 : (wptr_q + ADDR_ONE);
  end

  // Next-state logic for the FILL -> DRAIN -> DONE brick sequence.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    r_d     = r_q;
    maxc_d  = maxc_q;
    wptr_d  = wptr_q;
    base_d  = base_q;
    for (int l = 0; l < Tn; l++) begin
      cnt_d[l] = cnt_q[l];
    end

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          for (int l = 0; l < Tn; l++) begin
            cnt_d[l] = cnt_upd[l];
          end
          pos_d = pos_q + POS_ONE;
          if (brick_end) begin
            pos_d   = '0;
            base_d  = wptr_q;
            maxc_d  = maxc_upd;
            // A brick with no non-zero neurons skips straight to DONE so it
            // consumes no register-file rows.
            state_d = (maxc_upd != '0) ? ST_DRAIN : ST_DONE;
          end
        end
      end
      ST_DRAIN: begin
        wptr_d = wptr_inc;
        if (drain_last) begin
          r_d     = '0;
          state_d = ST_DONE;
        end else begin
          r_d = r_q + POS_ONE;
        end
      end
      ST_DONE: begin
        for (int l = 0; l < Tn; l++) begin
          cnt_d[l] = '0;
        end
        state_d = ST_FILL;
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase

    // Soft clear overrides the sequence and abandons any brick in flight.
    if (i_clear) begin
      state_d = ST_FILL;
      pos_d   = '0;
      r_d     = '0;
      wptr_d  = '0;
      for (int l = 0; l < Tn; l++) begin
        cnt_d[l] = '0;
      end
    end
  end

  // Ready is registered so it stays low throughout reset and follows state.
  always_comb begin
    ready_d = (state_d == ST_FILL);
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      ready_q <= 1'b0;
      pos_q   <= '0;
      r_q     <= '0;
      maxc_q  <= '0;
      wptr_q  <= '0;
      base_q  <= '0;
      for (int l = 0; l < Tn; l++) begin
        cnt_q[l] <= '0;
      end
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      pos_q   <= pos_d;
      r_q     <= r_d;
      maxc_q  <= maxc_d;
      wptr_q  <= wptr_d;
      base_q  <= base_d;
      for (int l = 0; l < Tn; l++) begin
        cnt_q[l] <= cnt_d[l];
      end
    end
  end

  // Staging writes: each non-zero lane appends its (value, pos) pair at the
  // lane's current fill depth. Stale entries are masked by cnt on readout.
  always_ff @(posedge clk) begin
    for (int l = 0; l < Tn; l++) begin
      if (accept && lane_nz[l]) begin
        stage_val_q[cnt_q[l][OFFSET_SZ-1:0]][l] <= lane_val[l];
        stage_off_q[cnt_q[l][OFFSET_SZ-1:0]][l] <= pos_q;
      end
    end
  end

  // Output muxing: the register-file port carries staging row r during
  // DRAIN, with lanes shorter than r padded to zero.
  always_comb begin
    o_ready       = ready_q;
    o_wen         = (state_q != ST_DRAIN);
    o_addr        = wptr_q;
    o_brick_done  = (state_q == ST_DONE);
    o_brick_len   = (state_q == ST_DONE) ? maxc_q : '0;
    o_brick_base  = (state_q == ST_DONE) ? base_q : '0;
    o_nbin_data   = '0;
    o_offset_data = '0;
    if (state_q == ST_DRAIN) begin
      for (int l = 0; l < Tn; l++) begin
        if ({1'b0, r_q} < cnt_q[l]) begin
          o_nbin_data[l*N +: N]                 = stage_val_q[r_q][l];
          o_offset_data[l*OFFSET_SZ +: OFFSET_SZ] = stage_off_q[r_q][l];
        end
      end
    end
  end

endmodule

// File: tb/tb_nbin_encoder.sv
// Directed testbench for nbin_encoder: reset, dense, sparse, all-zero,
// partial brick with address wrap, and soft clear in the middle of a drain.
module tb_nbin_encoder;

  localparam int N  = 16;
  localparam int TN = 16;
  localparam int OS = 4;
  localparam int AS = 6;

  logic             clk;
  logic             rst_n;
  logic             i_valid;
  logic             o_ready;
  logic [TN*N-1:0]  i_data;
  logic             i_last;
  logic             i_clear;
  logic [TN*N-1:0]  o_nbin_data;
  logic [TN*OS-1:0] o_offset_data;
  logic             o_wen;
  logic [AS-1:0]    o_addr;
  logic             o_brick_done;
  logic [OS:0]      o_brick_len;
  logic [AS-1:0]    o_brick_base;

  nbin_encoder #(.N(N), .Tn(TN), .OFFSET_SZ(OS), .ADDR_SZ(AS), .NUM_WORDS(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data       (i_data),
    .i_last       (i_last),
    .i_clear      (i_clear),
    .o_nbin_data  (o_nbin_data),
    .o_offset_data(o_offset_data),
    .o_wen        (o_wen),
    .o_addr       (o_addr),
    .o_brick_done (o_brick_done),
    .o_brick_len  (o_brick_len),
    .o_brick_base (o_brick_base)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Captured register-file writes and done pulse for one brick
  logic [TN*N-1:0]  wd [64];
  logic [TN*OS-1:0] wo [64];
  logic [AS-1:0]    wa [64];
  int               nw;
  int               ncyc;
  logic             done_seen;
  logic [OS:0]      dlen;
  logic [AS-1:0]    dbase;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [TN*N-1:0] putv(input logic [TN*N-1:0] v, input int l, input logic [N-1:0] x);
    logic [TN*N-1:0] r;
    r = v;
    r[l*N +: N] = x;
    return r;
  endfunction

  function automatic logic [TN*OS-1:0] puto(input logic [TN*OS-1:0] v, input int l, input logic [OS-1:0] x);
    logic [TN*OS-1:0] r;
    r = v;
    r[l*OS +: OS] = x;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [TN*N-1:0] d, input bit last);
    i_valid = 1'b1;
    i_data  = d;
    i_last  = last;
    step();
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_data  = '0;
  endtask

  // Records every write until the done pulse (bounded). With junk set the
  // source keeps presenting a row while the encoder is busy.
  task automatic collect(input bit junk);
    nw = 0;
    ncyc = 0;
    done_seen = 1'b0;
    dlen = '0;
    dbase = '0;
    if (junk) begin
      i_valid = 1'b1;
      i_data  = '1;
    end
    for (int k = 0; k < 40 && !done_seen; k++) begin
      ncyc++;
      if (!o_wen) begin
        if (nw < 64) begin
          wa[nw] = o_addr;
          wd[nw] = o_nbin_data;
          wo[nw] = o_offset_data;
        end
        nw++;
      end
      if (o_brick_done) begin
        done_seen = 1'b1;
        dlen      = o_brick_len;
        dbase     = o_brick_base;
        i_valid   = 1'b0;
        i_data    = '0;
      end
      step();
    end
    i_valid = 1'b0;
    i_data  = '0;
    chk("done_seen", done_seen, 1);
  endtask

  // n rows with lane 0 = i+1, i_last on the final row
  task automatic fill_brick(input int n, input logic [AS-1:0] first_addr);
    for (int i = 0; i < n; i++) begin
      send_row(putv('0, 0, N'(i + 1)), (i == n - 1));
    end
    collect(1'b0);
    chk("fill_nw", nw, n);
    chk("fill_first_addr", wa[0], first_addr);
    chk("fill_len", dlen, n);
  endtask

  logic [TN*N-1:0]  ed;
  logic [TN*OS-1:0] eo;
  logic             bad;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b1;
    i_data  = '1;
    i_last  = 1'b0;
    i_clear = 1'b0;

    // Reset held with a row offered
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", o_ready, 0);
    chk("rst_wen", o_wen, 1);
    chk("rst_addr", o_addr, 0);
    chk("rst_done", o_brick_done, 0);
    chk("rst_len", o_brick_len, 0);
    chk("rst_base", o_brick_base, 0);
    chk("rst_data", o_nbin_data, 0);
    chk("rst_off", o_offset_data, 0);
    rst_n   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    step();
    chk("rel_ready", o_ready, 1);

    // Dense brick: every lane non-zero at every position
    for (int p = 0; p < 16; p++) begin
      ed = '0;
      for (int l = 0; l < TN; l++) ed = putv(ed, l, N'(p * 16 + l + 1));
      send_row(ed, 1'b0);
    end
    collect(1'b1);
    chk("dense_nw", nw, 16);
    for (int r = 0; r < 16; r++) begin
      ed = '0;
      eo = '0;
      for (int l = 0; l < TN; l++) begin
        ed = putv(ed, l, N'(r * 16 + l + 1));
        eo = puto(eo, l, OS'(r));
      end
      chk($sformatf("dense_addr%0d", r), wa[r], AS'(r));
      chk($sformatf("dense_data%0d", r), wd[r], ed);
      chk($sformatf("dense_off%0d", r), wo[r], eo);
    end
    chk("dense_len", dlen, 16);
    chk("dense_base", dbase, 0);
    chk("dense_cycles", 16 + ncyc, 33);
    chk("dense_ready_after", o_ready, 1);

    // Soft clear to bring wptr back to 0
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    chk("clr0_ready", o_ready, 1);
    chk("clr0_addr", o_addr, 0);

    // Sparse brick
    for (int p = 0; p < 16; p++) begin
      ed = '0;
      if (p == 3)  ed = putv(ed, 0, 16'h0011);
      if (p == 7)  ed = putv(ed, 0, 16'h0022);
      if (p == 15) ed = putv(ed, 5, 16'h0033);
      send_row(ed, 1'b0);
    end
    collect(1'b0);
    chk("sparse_nw", nw, 2);
    chk("sparse_addr0", wa[0], 0);
    chk("sparse_data0", wd[0], putv(putv('0, 0, 16'h0011), 5, 16'h0033));
    chk("sparse_off0", wo[0], puto(puto('0, 0, 4'd3), 5, 4'd15));
    chk("sparse_addr1", wa[1], 1);
    chk("sparse_data1", wd[1], putv('0, 0, 16'h0022));
    chk("sparse_off1", wo[1], puto('0, 0, 4'd7));
    chk("sparse_len", dlen, 2);
    chk("sparse_base", dbase, 0);

    // All-zero brick: no writes, base is the current wptr (2)
    for (int p = 0; p < 16; p++) send_row('0, 1'b0);
    collect(1'b0);
    chk("zero_nw", nw, 0);
    chk("zero_len", dlen, 0);
    chk("zero_base", dbase, 2);

    // Advance wptr 2 -> 62; the first brick also confirms wptr stayed at 2
    fill_brick(16, 6'd2);
    fill_brick(16, 6'd18);
    fill_brick(16, 6'd34);
    fill_brick(12, 6'd50);

    // Partial brick wrapping the address space
    send_row(putv('0, 2, 16'd1), 1'b0);
    send_row(putv('0, 2, 16'd2), 1'b0);
    send_row(putv('0, 2, 16'd3), 1'b1);
    collect(1'b0);
    chk("wrap_nw", nw, 3);
    chk("wrap_addr0", wa[0], 62);
    chk("wrap_addr1", wa[1], 63);
    chk("wrap_addr2", wa[2], 0);
    chk("wrap_data0", wd[0], putv('0, 2, 16'd1));
    chk("wrap_data2", wd[2], putv('0, 2, 16'd3));
    chk("wrap_off0", wo[0], puto('0, 2, 4'd0));
    chk("wrap_off1", wo[1], puto('0, 2, 4'd1));
    chk("wrap_off2", wo[2], puto('0, 2, 4'd2));
    chk("wrap_len", dlen, 3);
    chk("wrap_base", dbase, 62);

    // Next brick restarts at pos 0
    send_row(putv('0, 0, 16'h0005), 1'b1);
    collect(1'b0);
    chk("restart_nw", nw, 1);
    chk("restart_addr", wa[0], 1);
    chk("restart_off", wo[0], '0);
    chk("restart_data", wd[0], putv('0, 0, 16'h0005));

    // Clear during the 2nd write of a dense brick
    for (int p = 0; p < 16; p++) begin
      ed = '0;
      for (int l = 0; l < TN; l++) ed = putv(ed, l, N'(p + 1));
      send_row(ed, 1'b0);
    end
    chk("clr_first_write", o_wen, 0);
    step();
    chk("clr_second_write", o_wen, 0);
    chk("clr_second_addr", o_addr, 3);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    chk("clr_wen", o_wen, 1);
    chk("clr_done", o_brick_done, 0);
    chk("clr_ready", o_ready, 1);
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (o_brick_done || !o_wen) bad = 1'b1;
      step();
    end
    chk("clr_quiet", bad, 0);
    send_row(putv('0, 3, 16'h0007), 1'b0);
    send_row(putv('0, 3, 16'h0008), 1'b1);
    collect(1'b0);
    chk("post_clr_nw", nw, 2);
    chk("post_clr_addr0", wa[0], 0);
    chk("post_clr_addr1", wa[1], 1);
    chk("post_clr_data0", wd[0], putv('0, 3, 16'h0007));
    chk("post_clr_off0", wo[0], puto('0, 3, 4'd0));
    chk("post_clr_off1", wo[1], puto('0, 3, 4'd1));
    chk("post_clr_base", dbase, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
